// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the Z80 bus and a DMA
// requester with round-robin grant and a setup/strobe/turnaround sequence.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int RAM_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cpu_cs_n,
  input  logic              i_cpu_rd_n,
  input  logic              i_cpu_wr_n,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_data,
  output logic [7:0]        o_cpu_data,
  output logic              o_cpu_wait_n,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [7:0]        i_dma_data,
  output logic [7:0]        o_dma_data,
  output logic              o_dma_ack,
  output logic              o_ram_cs_n,
  output logic              o_ram_wr_n,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_data,
  input  logic [7:0]        i_ram_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [2:0] LP_WAIT  = 3'(RAM_WAIT);

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_cpu_done;
  logic              r_last_dma;
  logic              r_gnt_dma;
  logic              r_we;
  logic              r_dma_ack;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_cpu_rdata;
  logic [7:0]        r_dma_rdata;

  logic w_cpu_req;
  logic w_cpu_pend;
  logic w_dma_pend;
  logic w_pick_dma;
  logic w_start;
  logic w_last;
  logic w_active;

  assign w_cpu_req  = ~i_cpu_cs_n & (~i_cpu_rd_n | ~i_cpu_wr_n);
  assign w_cpu_pend = w_cpu_req & ~r_cpu_done;
  // The ack cycle masks the DMA request so a held req is not re-served.
  assign w_dma_pend = i_dma_req & ~r_dma_ack;
  assign w_pick_dma = w_dma_pend & (~w_cpu_pend | ~r_last_dma);
  assign w_start    = (r_state == S_IDLE) & (w_cpu_pend | w_dma_pend);
  assign w_last     = (r_state == S_STROBE) & (r_cnt == LP_WAIT);
  assign w_active   = (r_state == S_SETUP) | (r_state == S_STROBE);

  assign o_cpu_wait_n = ~w_cpu_pend;
  assign o_ram_cs_n   = ~w_active;
  assign o_ram_wr_n   = ~((r_state == S_STROBE) & r_we);
  assign o_ram_addr   = r_addr;
  assign o_ram_data   = r_wdata;
  assign o_cpu_data   = r_cpu_rdata;
  assign o_dma_data   = r_dma_rdata;
  assign o_dma_ack    = r_dma_ack;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) r_state <= S_SETUP;
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_cnt   <= '0;
        end
        S_STROBE: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cpu_done  <= 1'b0;
      r_last_dma  <= 1'b1;
      r_gnt_dma   <= 1'b0;
      r_we        <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_dma_ack <= w_last & r_gnt_dma;
      if (w_start) begin
        r_gnt_dma  <= w_pick_dma;
        r_last_dma <= w_pick_dma;
        r_addr     <= w_pick_dma ? i_dma_addr : i_cpu_addr;
        r_wdata    <= w_pick_dma ? i_dma_data : i_cpu_data;
        r_we       <= w_pick_dma ? i_dma_we : ~i_cpu_wr_n;
      end
      // A CPU that let go of cs_n mid-access must not leave done stuck.
      if (w_last & ~r_gnt_dma) begin
        r_cpu_done <= w_cpu_req;
      end else if (!w_cpu_req) begin
        r_cpu_done <= 1'b0;
      end
      if (w_last & ~r_we) begin
        if (r_gnt_dma) r_dma_rdata <= i_ram_data;
        else r_cpu_rdata <= i_ram_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against
// a transaction-level model (memory image, access lengths, grant order).
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int AW  = 19;
  localparam int W   = 1;
  localparam int OCC = W + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cpu_cs_n = 1'b1;
  logic          cpu_rd_n = 1'b1;
  logic          cpu_wr_n = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          wait_n;
  logic          dma_req = 1'b0;
  logic          dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_wdata = '0;
  logic [7:0]    dma_rdata;
  logic          dma_ack;
  logic          ram_cs_n;
  logic          ram_wr_n;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  sram_arbiter #(.ADDR_W(AW), .RAM_WAIT(W)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_cs_n(cpu_cs_n), .i_cpu_rd_n(cpu_rd_n), .i_cpu_wr_n(cpu_wr_n),
    .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_wdata),
    .o_cpu_data(cpu_rdata), .o_cpu_wait_n(wait_n),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
    .i_dma_data(dma_wdata), .o_dma_data(dma_rdata), .o_dma_ack(dma_ack),
    .o_ram_cs_n(ram_cs_n), .o_ram_wr_n(ram_wr_n), .o_ram_addr(ram_addr),
    .o_ram_data(ram_wdata), .i_ram_data(ram_rdata)
  );

  // SRAM model plus a preload path for the bench
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (rst_n && !ram_cs_n && !ram_wr_n) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  // RAM_WAIT sweep instances: DMA port only
  logic [1:0]    sw_req = '0;
  logic [1:0]    sw_we = '0;
  logic [7:0]    sw_wdata [2];
  logic [7:0]    sw_rdata [2];
  logic [1:0]    sw_ack;
  logic [1:0]    sw_cs_n;
  logic [1:0]    sw_wr_n;
  logic [1:0]    sw_wait_n;
  logic [7:0]    sw_cpu_rd [2];
  logic [AW-1:0] sw_raddr [2];
  logic [7:0]    sw_rwdata [2];
  logic [7:0]    sw_mem [2];
  logic [7:0]    sw_ram_rd [2];
  logic [AW-1:0] sw_addr = 19'h00005;
  assign sw_ram_rd[0] = sw_mem[0];
  assign sw_ram_rd[1] = sw_mem[1];

  sram_arbiter #(.ADDR_W(AW), .RAM_WAIT(0)) u_w0 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_cs_n(1'b1), .i_cpu_rd_n(1'b1), .i_cpu_wr_n(1'b1),
    .i_cpu_addr(sw_addr), .i_cpu_data(8'h00),
    .o_cpu_data(sw_cpu_rd[0]), .o_cpu_wait_n(sw_wait_n[0]),
    .i_dma_req(sw_req[0]), .i_dma_we(sw_we[0]), .i_dma_addr(sw_addr),
    .i_dma_data(sw_wdata[0]), .o_dma_data(sw_rdata[0]), .o_dma_ack(sw_ack[0]),
    .o_ram_cs_n(sw_cs_n[0]), .o_ram_wr_n(sw_wr_n[0]), .o_ram_addr(sw_raddr[0]),
    .o_ram_data(sw_rwdata[0]), .i_ram_data(sw_ram_rd[0])
  );

  sram_arbiter #(.ADDR_W(AW), .RAM_WAIT(3)) u_w3 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_cs_n(1'b1), .i_cpu_rd_n(1'b1), .i_cpu_wr_n(1'b1),
    .i_cpu_addr(sw_addr), .i_cpu_data(8'h00),
    .o_cpu_data(sw_cpu_rd[1]), .o_cpu_wait_n(sw_wait_n[1]),
    .i_dma_req(sw_req[1]), .i_dma_we(sw_we[1]), .i_dma_addr(sw_addr),
    .i_dma_data(sw_wdata[1]), .o_dma_data(sw_rdata[1]), .o_dma_ack(sw_ack[1]),
    .o_ram_cs_n(sw_cs_n[1]), .o_ram_wr_n(sw_wr_n[1]), .o_ram_addr(sw_raddr[1]),
    .o_ram_data(sw_rwdata[1]), .i_ram_data(sw_ram_rd[1])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (!sw_cs_n[k] && !sw_wr_n[k]) sw_mem[k] <= sw_rwdata[k];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // access monitor: one record per cs_n-low run
  typedef struct {
    int            start;
    int            len;
    int            wlen;
    logic [AW-1:0] addr;
  } acc_t;
  acc_t          acc_q[$];
  int            run = 0;
  int            wrun = 0;
  int            rstart = 0;
  logic [AW-1:0] raddr = '0;
  int            ack_cnt = 0;
  logic          ack_prev = 1'b0;
  int            sw_run [2] = '{0, 0};
  int            sw_wrun [2] = '{0, 0};
  int            sw_len [2] = '{0, 0};
  int            sw_wlen [2] = '{0, 0};

  always @(negedge clk) begin
    if (!ram_cs_n) begin
      if (run == 0) begin
        rstart = cyc;
        raddr = ram_addr;
      end
      run++;
      if (!ram_wr_n) wrun++;
    end else if (run > 0) begin
      acc_q.push_back('{rstart, run, wrun, raddr});
      if (rst_n) check("acc_len", run, W + 2);
      run = 0;
      wrun = 0;
    end
    if (dma_ack) begin
      ack_cnt++;
      check("ack_width", 32'(ack_prev), 0);
    end
    ack_prev = dma_ack;
    for (int k = 0; k < 2; k++) begin
      if (!sw_cs_n[k]) begin
        sw_run[k]++;
        if (!sw_wr_n[k]) sw_wrun[k]++;
      end else if (sw_run[k] > 0) begin
        sw_len[k] = sw_run[k];
        sw_wlen[k] = sw_wrun[k];
        sw_run[k] = 0;
        sw_wrun[k] = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    step(1);
    pre_we = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d, input int hold,
                        output logic [7:0] rd, output int lat);
    cpu_addr = a;
    cpu_wdata = d;
    cpu_rd_n = we;
    cpu_wr_n = !we;
    cpu_cs_n = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!wait_n && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    rd = cpu_rdata;
    repeat (hold) @(negedge clk);
    step(1);
    cpu_cs_n = 1'b1;
    cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1;
    step(1);
  endtask

  task automatic dma_op(input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    dma_addr = a;
    dma_wdata = d;
    dma_we = we;
    dma_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!dma_ack && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    rd = dma_rdata;
    step(1);
    dma_req = 1'b0;
  endtask

  task automatic sw_op(input int k, input logic we, input logic [7:0] d,
                       output logic [7:0] rd, output int lat);
    sw_we[k] = we;
    sw_wdata[k] = d;
    sw_req[k] = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!sw_ack[k] && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    rd = sw_rdata[k];
    step(1);
    sw_req[k] = 1'b0;
  endtask

  logic [7:0] ref_mem [int];
  logic [7:0] rd_c, rd_d;
  int         lat_c, lat_d;
  int         n0, k0;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    sw_wdata[0] = '0;
    sw_wdata[1] = '0;
    // reset state, with a CPU request visible during reset
    cpu_cs_n = 1'b0;
    cpu_rd_n = 1'b0;
    #12;
    check("rst_wait_n_req", 32'(wait_n), 0);
    cpu_cs_n = 1'b1;
    cpu_rd_n = 1'b1;
    #1;
    check("rst_cs_n", 32'(ram_cs_n), 1);
    check("rst_wr_n", 32'(ram_wr_n), 1);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_cpu_data", 32'(cpu_rdata), 0);
    check("rst_dma_data", 32'(dma_rdata), 0);
    check("rst_ack", 32'(dma_ack), 0);
    check("rst_wait_n", 32'(wait_n), 1);
    step(1);
    rst_n = 1'b1;
    step(1);

    // tie after reset: CPU first, DMA one IDLE cycle later
    n0 = acc_q.size();
    fork
      cpu_op(1'b1, 19'h00200, 8'h11, 0, rd_c, lat_c);
      dma_op(1'b1, 19'h40200, 8'h22, rd_d, lat_d);
    join
    check("tie_cpu_lat", lat_c, OCC);
    check("tie_dma_lat", lat_d, 2 * OCC);
    check("tie_count", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2) begin
      check("tie_first", 32'(acc_q[n0].addr), 'h00200);
      check("tie_second", 32'(acc_q[n0+1].addr), 'h40200);
      check("tie_gap", acc_q[n0+1].start,
            acc_q[n0].start + acc_q[n0].len + 1);
    end

    // uncontended CPU read, cs_n held after completion
    preload(19'h12345, 8'hA5);
    n0 = acc_q.size();
    cpu_op(1'b0, 19'h12345, 8'h00, 3, rd_c, lat_c);
    check("cpu_rd_wait", lat_c, 4);
    check("cpu_rd_data", 32'(rd_c), 'hA5);
    check("cpu_rd_count", acc_q.size() - n0, 1);
    if (acc_q.size() > n0) begin
      check("cpu_rd_cs_len", acc_q[n0].len, 3);
      check("cpu_rd_wr_len", acc_q[n0].wlen, 0);
      check("cpu_rd_addr", 32'(acc_q[n0].addr), 'h12345);
    end

    // tie right after a CPU grant goes to DMA
    n0 = acc_q.size();
    fork
      cpu_op(1'b1, 19'h00210, 8'h33, 0, rd_c, lat_c);
      dma_op(1'b1, 19'h40210, 8'h44, rd_d, lat_d);
    join
    check("rr_count", acc_q.size() - n0, 2);
    if (acc_q.size() >= n0 + 2) begin
      check("rr_first", 32'(acc_q[n0].addr), 'h40210);
      check("rr_second", 32'(acc_q[n0+1].addr), 'h00210);
    end

    // DMA write then read back
    k0 = ack_cnt;
    n0 = acc_q.size();
    dma_op(1'b1, 19'h00010, 8'h3C, rd_d, lat_d);
    check("dma_wr_lat", lat_d, 4);
    if (acc_q.size() > n0) check("dma_wr_len", acc_q[n0].wlen, 2);
    dma_op(1'b0, 19'h00010, 8'h00, rd_d, lat_d);
    check("dma_rd_lat", lat_d, 4);
    check("dma_rd_data", 32'(rd_d), 'h3C);
    check("dma_acks", ack_cnt - k0, 2);
    check("dma_mem", 32'(mem[19'h00010]), 'h3C);

    // both held back-to-back: CPU/DMA/CPU/DMA
    n0 = acc_q.size();
    fork
      begin
        cpu_op(1'b1, 19'h00220, 8'h01, 0, rd_c, lat_c);
        cpu_op(1'b1, 19'h00221, 8'h02, 0, rd_c, lat_c);
      end
      begin
        dma_op(1'b1, 19'h40220, 8'h03, rd_d, lat_d);
        dma_op(1'b1, 19'h40221, 8'h04, rd_d, lat_d);
      end
    join
    check("alt_count", acc_q.size() - n0, 4);
    if (acc_q.size() >= n0 + 4) begin
      check("alt_0", 32'(acc_q[n0].addr), 'h00220);
      check("alt_1", 32'(acc_q[n0+1].addr), 'h40220);
      check("alt_2", 32'(acc_q[n0+2].addr), 'h00221);
      check("alt_3", 32'(acc_q[n0+3].addr), 'h40221);
    end

    // DMA request withdrawn before grant
    n0 = acc_q.size();
    k0 = ack_cnt;
    fork
      cpu_op(1'b1, 19'h00230, 8'h55, 0, rd_c, lat_c);
      begin
        step(2);
        dma_addr = 19'h40230;
        dma_we = 1'b1;
        dma_req = 1'b1;
        step(1);
        dma_req = 1'b0;
      end
    join
    step(2);
    check("wd_dma_count", acc_q.size() - n0, 1);
    check("wd_dma_ack", ack_cnt - k0, 0);

    // DMA request dropped after grant still completes
    k0 = ack_cnt;
    dma_addr = 19'h40310;
    dma_wdata = 8'h5A;
    dma_we = 1'b1;
    dma_req = 1'b1;
    step(1);
    dma_req = 1'b0;
    for (int i = 0; i < 10 && ack_cnt == k0; i++) @(negedge clk);
    step(1);
    check("drop_dma_ack", ack_cnt - k0, 1);
    check("drop_dma_mem", 32'(mem[19'h40310]), 'h5A);

    // CPU write with cs_n released during STROBE
    cpu_addr = 19'h00300;
    cpu_wdata = 8'h77;
    cpu_wr_n = 1'b0;
    cpu_cs_n = 1'b0;
    step(3);
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    step(3);
    check("wd_cpu_mem", 32'(mem[19'h00300]), 'h77);
    cpu_op(1'b0, 19'h00300, 8'h00, 0, rd_c, lat_c);
    check("wd_cpu_next_lat", lat_c, 4);
    check("wd_cpu_next_data", 32'(rd_c), 'h77);

    // RAM_WAIT sweep: 0 and 3
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 0 : 3;
      sw_op(k, 1'b1, 8'h90 + 8'(k), rd_d, lat_d);
      check("sw_wr_lat", lat_d, w + 3);
      check("sw_cs_len", sw_len[k], w + 2);
      check("sw_wr_len", sw_wlen[k], w + 1);
      sw_op(k, 1'b0, 8'h00, rd_d, lat_d);
      check("sw_rd_lat", lat_d, w + 3);
      check("sw_rd_wlen", sw_wlen[k], 0);
      check("sw_rd_data", 32'(rd_d), 32'h90 + k);
    end

    // reset during a DMA write strobe
    k0 = ack_cnt;
    dma_addr = 19'h40400;
    dma_wdata = 8'hEE;
    dma_we = 1'b1;
    dma_req = 1'b1;
    step(2);
    check("mid_wr_n_low", 32'(ram_wr_n), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_cs_n", 32'(ram_cs_n), 1);
    check("mid_wr_n", 32'(ram_wr_n), 1);
    step(3);
    dma_req = 1'b0;
    check("mid_no_ack", ack_cnt - k0, 0);
    rst_n = 1'b1;
    step(1);
    n0 = acc_q.size();
    fork
      cpu_op(1'b1, 19'h00240, 8'h66, 0, rd_c, lat_c);
      dma_op(1'b1, 19'h40240, 8'h67, rd_d, lat_d);
    join
    check("mid_no_ack_after", ack_cnt - k0, 1);
    if (acc_q.size() >= n0 + 2) begin
      check("mid_tie_first", 32'(acc_q[n0].addr), 'h00240);
      check("mid_tie_second", 32'(acc_q[n0+1].addr), 'h40240);
    end

    // randomized concurrent traffic against a memory-image model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      preload(AW'(32'h00100 + i), v);
      ref_mem[32'h00100 + i] = v;
      v = 8'($urandom);
      preload(AW'(32'h40100 + i), v);
      ref_mem[32'h40100 + i] = v;
    end
    fork
      begin : cpu_thr
        logic [7:0] r;
        int l;
        int a;
        logic we;
        logic [7:0] d;
        for (int t = 0; t < 25; t++) begin
          a = 32'h00100 + int'($urandom_range(0, 15));
          we = 1'($urandom);
          d = 8'($urandom);
          if (we) ref_mem[a] = d;
          cpu_op(we, AW'(a), d, 0, r, l);
          check("rnd_cpu_lat", 32'(l >= OCC && l <= 2 * OCC), 1);
          if (!we) check("rnd_cpu_data", 32'(r), 32'(ref_mem[a]));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin : dma_thr
        logic [7:0] r;
        int l;
        int a;
        logic we;
        logic [7:0] d;
        for (int t = 0; t < 25; t++) begin
          a = 32'h40100 + int'($urandom_range(0, 15));
          we = 1'($urandom);
          d = 8'($urandom);
          if (we) ref_mem[a] = d;
          dma_op(we, AW'(a), d, r, l);
          check("rnd_dma_lat", 32'(l >= OCC && l <= 2 * OCC), 1);
          if (!we) check("rnd_dma_data", 32'(r), 32'(ref_mem[a]));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    step(2);
    for (int i = 0; i < 16; i++) begin
      check("rnd_mem_cpu", 32'(mem[AW'(32'h00100 + i)]),
            32'(ref_mem[32'h00100 + i]));
      check("rnd_mem_dma", 32'(mem[AW'(32'h40100 + i)]),
            32'(ref_mem[32'h40100 + i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
